// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner_if
// Brief    : Load handshake and display pins of the seven-segment scanner.
//            master = value producer / board side, slave = scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if;
  logic        en_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        ready_o;
  logic        frame_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  modport master (
    output en_i, load_i, value_i, dp_i,
    input  ready_o, frame_o, an_o, seg_o, dp_o
  );

  modport slave (
    input  en_i, load_i, value_i, dp_i,
    output ready_o, frame_o, an_o, seg_o, dp_o
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Brief    : Time-multiplexed 4-digit hex seven-segment driver. A new value is
//            staged in a pending register and copied to the display register
//            only at a frame boundary, so a frame never shows mixed values.
//            Optional: define SEVEN_SEGMENT_LZ_BLANK_EN to blank leading zeros
//            on digits 3..1.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
  parameter int DIV = 25000
) (
  input  logic                   clk,
  input  logic                   rst,
  seven_segment_scanner_if.slave bus
);

  localparam logic [15:0] c_last = 16'(DIV - 1);

  logic [15:0] r_presc;
  logic [1:0]  r_index;
  logic        r_ready;
  logic        r_frame;
  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic [15:0] r_disp_val;
  logic [3:0]  r_disp_dp;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_tick;
  logic        w_boundary;
  logic        w_accept;
  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [6:0]  w_seg;

  assign w_tick     = (r_presc == c_last);
  assign w_boundary = w_tick && (r_index == 2'd3);
  assign w_accept   = bus.load_i && r_ready;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h7C;
      4'hC: f_decode = 7'h39;
      4'hD: f_decode = 7'h5E;
      4'hE: f_decode = 7'h79;
      default: f_decode = 7'h71;
    endcase
  endfunction

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    w_nibble = r_disp_val[{r_index, 2'b00} +: 4];
  end

`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_index)
      2'd3:    w_blank = (r_disp_val[15:12] == 4'h0);
      2'd2:    w_blank = (r_disp_val[15:8] == 8'h00);
      2'd1:    w_blank = (r_disp_val[15:4] == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = w_blank ? 7'h00 : f_decode(w_nibble);

  // Prescaler and digit index: one digit slot every DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 16'd0;
      r_index <= 2'd0;
    end else if (w_tick) begin
      r_presc <= 16'd0;
      r_index <= r_index + 2'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Load handshake: capture when ready, hand over at the next frame boundary.
  // A load accepted in the boundary cycle sees ready high, so the transfer
  // branch cannot fire until the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b1;
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_disp_val <= 16'h0000;
      r_disp_dp  <= 4'h0;
    end else if (w_accept) begin
      r_pend_val <= bus.value_i;
      r_pend_dp  <= bus.dp_i;
      r_ready    <= 1'b0;
    end else if (!r_ready && w_boundary) begin
      r_disp_val <= r_pend_val;
      r_disp_dp  <= r_pend_dp;
      r_ready    <= 1'b1;
    end
  end

  // Registered display outputs, blanked while the display is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= 1'b0;
      r_an    <= 4'h0;
      r_seg   <= 7'h00;
      r_dp    <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (bus.en_i) begin
        r_an  <= 4'b0001 << r_index;
        r_seg <= w_seg;
        r_dp  <= r_disp_dp[r_index];
      end else begin
        r_an  <= 4'h0;
        r_seg <= 7'h00;
        r_dp  <= 1'b0;
      end
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.frame_o = r_frame;
  assign bus.an_o    = r_an;
  assign bus.seg_o   = r_seg;
  assign bus.dp_o    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Brief    : Directed self-checking bench for seven_segment_scanner, DIV=4.
//            Honours SEVEN_SEGMENT_LZ_BLANK_EN for the leading-zero vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

  localparam int c_div = 4;

`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
  localparam logic [6:0] c_lz = 7'h00;
`else
  localparam logic [6:0] c_lz = 7'h3F;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  seven_segment_scanner_if bus ();

  seven_segment_scanner #(.DIV(c_div)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 16-cycle frame, starting right after a boundary edge.
  // off: leading cycles with en_i low; inj: cycle index of a load (-1: none);
  // spur: also drive an FFFF load the cycle after inj (must be ignored).
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dps, input int off, input int inj,
                           input logic [15:0] iv, input logic [3:0] idp,
                           input bit spur);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int j = 0; j < 16; j++) begin
      int d;
      logic [3:0] ea;
      d  = j / 4;
      ea = 4'b0001 << d;
      bus.en_i   = (j >= off);
      bus.load_i = 1'b0;
      if (j == inj) begin
        bus.load_i  = 1'b1;
        bus.value_i = iv;
        bus.dp_i    = idp;
      end
      if (spur && inj >= 0 && j == inj + 1) begin
        bus.load_i  = 1'b1;
        bus.value_i = 16'hFFFF;
        bus.dp_i    = 4'hF;
      end
      step();
      if (j < off) begin
        check($sformatf("an_off%0d", j), 16'(bus.an_o), 16'h0);
        check($sformatf("seg_off%0d", j), 16'(bus.seg_o), 16'h0);
        check($sformatf("dp_off%0d", j), 16'(bus.dp_o), 16'h0);
      end else begin
        check($sformatf("an%0d", j), 16'(bus.an_o), 16'(ea));
        check($sformatf("seg%0d", j), 16'(bus.seg_o), 16'(s[d]));
        check($sformatf("dp%0d", j), 16'(bus.dp_o), 16'(dps[d]));
      end
      check($sformatf("frame%0d", j), 16'(bus.frame_o), 16'(j == 15));
      if (inj >= 0 && j == inj + 1)
        check("ready_low", 16'(bus.ready_o), 16'h0);
    end
    bus.load_i = 1'b0;
    bus.en_i   = 1'b1;
  endtask

  initial begin
    bus.en_i    = 1'b1;
    bus.load_i  = 1'b0;
    bus.value_i = 16'h0000;
    bus.dp_i    = 4'h0;
    rst         = 1'b1;
    step();
    step();
    check("rst_ready", 16'(bus.ready_o), 16'h1);
    check("rst_frame", 16'(bus.frame_o), 16'h0);
    check("rst_an", 16'(bus.an_o), 16'h0);
    check("rst_seg", 16'(bus.seg_o), 16'h0);
    check("rst_dp", 16'(bus.dp_o), 16'h0);
    rst = 1'b0;

    // Idle scan: all zeros, frame pulse every 16 cycles.
    run_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, -1, 16'h0, 4'h0, 1'b0);
    run_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, -1, 16'h0, 4'h0, 1'b0);

    // Mid-frame load of 12AF plus an ignored FFFF load while pending.
    run_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, 1, 16'h12AF, 4'b0100, 1'b1);
    check("ready_back", 16'(bus.ready_o), 16'h1);
    run_frame(7'h71, 7'h77, 7'h5B, 7'h06, 4'b0100, 0, -1, 16'h0, 4'h0, 1'b0);

    // Load in the boundary cycle: next frame still old, frame after is new.
    run_frame(7'h71, 7'h77, 7'h5B, 7'h06, 4'b0100, 0, 15, 16'h0050, 4'b0001, 1'b0);
    check("ready_bnd_low", 16'(bus.ready_o), 16'h0);
    run_frame(7'h71, 7'h77, 7'h5B, 7'h06, 4'b0100, 0, -1, 16'h0, 4'h0, 1'b0);
    check("ready_bnd_back", 16'(bus.ready_o), 16'h1);

    // New value 0050 with display disabled for the first 10 cycles.
    run_frame(7'h3F, 7'h6D, c_lz, c_lz, 4'b0001, 10, -1, 16'h0, 4'h0, 1'b0);

    // Reset while a load is pending discards it.
    bus.load_i  = 1'b1;
    bus.value_i = 16'hBEEF;
    bus.dp_i    = 4'hF;
    step();
    bus.load_i = 1'b0;
    check("pend_ready", 16'(bus.ready_o), 16'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 16'(bus.ready_o), 16'h1);
    check("arst_an", 16'(bus.an_o), 16'h0);
    check("arst_seg", 16'(bus.seg_o), 16'h0);
    check("arst_frame", 16'(bus.frame_o), 16'h0);
    step();
    step();
    rst = 1'b0;
    run_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, -1, 16'h0, 4'h0, 1'b0);
    run_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, -1, 16'h0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
